// File: rtl/memory_write_control.sv
// Store-side byte-serial write controller: takes one store request and writes it
// to a byte-wide memory, lowest address first, one byte per cycle.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; no write strobe
// S_WRITE | presenting one byte per cycle on the memory port
// S_DONE  | one-cycle completion pulse; a new start is accepted here too
module memory_write_control (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] address,
    input  logic [2:0]  mode,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] mem_address,
    output logic [7:0]  mem_write_data,
    output logic        mem_write_enable
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [2:0]  remaining_q;
    logic [1:0]  index_q;
    logic        busy_q;
    logic        done_q;
    logic        we_q;
    logic [31:0] mem_addr_q;
    logic [7:0]  mem_data_q;

    logic [2:0]  len_d;
    logic [1:0]  index_d;
    logic [31:0] mem_addr_d;
    logic [7:0]  mem_data_d;

    // mode[2] only distinguishes signed/unsigned loads; stores ignore it
    logic        unused_mode;
    assign unused_mode = mode[2];

    always_comb begin
        len_d      = 3'd1;
        index_d    = index_q + 2'd1;
        mem_addr_d = addr_q + {30'd0, index_d};
        mem_data_d = data_q[{index_d, 3'b000} +: 8];
        case (mode[1:0])
            2'b00:   len_d = 3'd1;
            2'b01:   len_d = 3'd2;
            default: len_d = 3'd4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            remaining_q <= '0;
            index_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // byte 0 goes out on the cycle right after acceptance
                        state_q     <= S_WRITE;
                        addr_q      <= address;
                        data_q      <= write_data;
                        remaining_q <= len_d;
                        index_q     <= 2'd0;
                        busy_q      <= 1'b1;
                        we_q        <= 1'b1;
                        mem_addr_q  <= address;
                        mem_data_q  <= write_data[7:0];
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        we_q    <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (remaining_q == 3'd1) begin
                        state_q     <= S_DONE;
                        remaining_q <= 3'd0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        we_q        <= 1'b0;
                    end else begin
                        index_q     <= index_d;
                        remaining_q <= remaining_q - 3'd1;
                        mem_addr_q  <= mem_addr_d;
                        mem_data_q  <= mem_data_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign mem_address      = mem_addr_q;
    assign mem_write_data   = mem_data_q;
    assign mem_write_enable = we_q;

endmodule

// File: tb/tb_memory_write_control.sv
// Scoreboard bench for memory_write_control: expected byte writes are queued when
// a store is issued and popped as the write strobe appears.
module tb_memory_write_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] address = '0;
    logic [2:0]  mode = '0;
    logic [31:0] write_data = '0;
    logic        busy;
    logic        done;
    logic [31:0] mem_address;
    logic [7:0]  mem_write_data;
    logic        mem_write_enable;

    memory_write_control dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .address          (address),
        .mode             (mode),
        .write_data       (write_data),
        .busy             (busy),
        .done             (done),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        exp_q[$];
    bit [7:0]   mem [bit [31:0]];
    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    int         we_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // memory model and scoreboard consumer; outputs are stable at the falling edge
    always @(negedge clk) begin
        wr_t e;
        if (done === 1'b1) done_cnt++;
        if (mem_write_enable === 1'b1) begin
            we_cnt++;
            mem[mem_address] = mem_write_data;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_address, e.a);
                chk("wr_data", mem_write_data, e.d);
            end
        end
    end

    function automatic int store_len(input logic [2:0] m);
        return m[1] ? 4 : (m[0] ? 2 : 1);
    endfunction

    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
        for (int k = 0; k < store_len(m); k++) begin
            wr_t e;
            e.a = a + k;
            e.d = d[8*k +: 8];
            exp_q.push_back(e);
        end
    endtask

    // now=1 drives start in the current cycle (used from a done cycle)
    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                             input bit poke, input bit now);
        int n;
        int lat;
        int busy_n;
        n = store_len(m);
        if (!now) @(negedge clk);
        address    = a;
        write_data = d;
        mode       = m;
        start      = 1'b1;
        push_store(a, d, m);
        @(negedge clk);
        start      = 1'b0;
        address    = ~a;
        write_data = ~d;
        mode       = ~m;
        lat        = 1;
        busy_n     = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_n++;
            start = (poke && lat == 2);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("latency", lat, n + 1);
        chk("busy_cycles", busy_n, n);
        chk("done_busy", busy, 1'b0);
        chk("done_we", mem_write_enable, 1'b0);
    endtask

    initial begin
        logic [31:0] w;
        int d0;
        int w0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_we", mem_write_enable, 1'b0);
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_data", mem_write_data, 8'h0);
        reset = 1'b0;

        run_store(32'h100, 32'hDEADBEEF, 3'b010, 1'b0, 1'b0);
        w = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) chk("readback_word", mem[32'h100 + k], w[8*k +: 8]);

        run_store(32'h20, 32'h12345678, 3'b100, 1'b0, 1'b0);
        chk("readback_byte", mem[32'h20], 8'h78);
        run_store(32'h30, 32'h12345678, 3'b101, 1'b0, 1'b0);
        chk("readback_half0", mem[32'h30], 8'h78);
        chk("readback_half1", mem[32'h31], 8'h56);

        run_store(32'hFFFFFFFE, 32'hA1B2C3D4, 3'b010, 1'b0, 1'b0);
        chk("wrap_lo", mem[32'h0], 8'hB2);
        chk("wrap_hi", mem[32'h1], 8'hA1);

        // a start pulse mid-store must not disturb the sequence; the follow-up
        // byte store is issued in the done cycle itself
        run_store(32'h500, 32'h0BADF00D, 3'b010, 1'b1, 1'b0);
        run_store(32'h40, 32'h00000099, 3'b000, 1'b0, 1'b1);
        chk("readback_b2b", mem[32'h40], 8'h99);

        @(negedge clk);
        address    = 32'h200;
        write_data = 32'h11223344;
        mode       = 3'b010;
        start      = 1'b1;
        push_store(32'h200, 32'h00003344, 3'b001);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        d0    = done_cnt;
        @(negedge clk);
        reset = 1'b0;
        w0    = we_cnt;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_we", mem_write_enable, 1'b0);
        chk("abort_addr", mem_address, 32'h0);
        chk("abort_data", mem_write_data, 8'h0);
        repeat (6) @(negedge clk);
        chk("abort_no_more_wr", we_cnt, w0);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_202_untouched", mem.exists(32'h202), 1'b0);

        run_store(32'h300, 32'hCAFEF00D, 3'b010, 1'b0, 1'b0);
        chk("after_abort_rb", mem[32'h303], 8'hCA);

        repeat (2) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
